// File: rtl/vdp_vram_arbiter_if.sv
// VRAM pin bundle between the VDP arbiter and the external VRAM.
//   vram_addr  : access address (arbiter -> VRAM)
//   vram_dout  : write data     (arbiter -> VRAM)
//   vram_din   : read data      (VRAM -> arbiter)
//   vram_ce_n  : chip enable, active low
//   vram_oe_n  : output enable, active low
//   vram_we_n  : write enable, active low
interface vdp_vram_arbiter_if #(
    parameter int unsigned AW = 14
) ();
    logic [AW-1:0] vram_addr;
    logic [7:0]    vram_dout;
    logic [7:0]    vram_din;
    logic          vram_ce_n;
    logic          vram_oe_n;
    logic          vram_we_n;

    modport master (
        output vram_addr,
        output vram_dout,
        output vram_ce_n,
        output vram_oe_n,
        output vram_we_n,
        input  vram_din
    );

    modport slave (
        input  vram_addr,
        input  vram_dout,
        input  vram_ce_n,
        input  vram_oe_n,
        input  vram_we_n,
        output vram_din
    );
endinterface

// File: rtl/vdp_vram_arbiter.sv
// VDP VRAM access arbiter.
// Render fetches run in slots assigned by the video timing generator; CPU data-port
// traffic uses the free CPU slots. Holds the CPU VRAM address register (auto-increment),
// a one-entry pending-operation register and the CPU read-ahead buffer.
// Ports:
//   MCLK, RESET            : master clock, asynchronous active-low reset
//   slot_tick, slot_type   : slot start pulse and its kind (00 CPU, 01 render, 1x refresh)
//   ren_addr/data/valid    : render fetch address in, data + one-cycle valid out
//   cpu_addr_wr/addr/rd_ahead, cpu_rd_req, cpu_wr_req/wdata : CPU data-port requests
//   cpu_rdata, cpu_busy, cpu_overrun : read buffer, busy flag, lost-op pulse
//   vram                   : VRAM pin bundle (master side)
module vdp_vram_arbiter #(
    parameter int unsigned ACC_CYC = 4,
    parameter int unsigned AW      = 14
) (
    input  logic          MCLK,
    input  logic          RESET,
    input  logic          slot_tick,
    input  logic [1:0]    slot_type,
    input  logic [AW-1:0] ren_addr,
    output logic [7:0]    ren_data,
    output logic          ren_valid,
    input  logic          cpu_addr_wr,
    input  logic [AW-1:0] cpu_addr,
    input  logic          cpu_rd_ahead,
    input  logic          cpu_rd_req,
    input  logic          cpu_wr_req,
    input  logic [7:0]    cpu_wdata,
    output logic [7:0]    cpu_rdata,
    output logic          cpu_busy,
    output logic          cpu_overrun,
    vdp_vram_arbiter_if.master vram
);

    typedef enum logic [1:0] {StIdle, StRen, StCpuRd, StCpuWr} state_e;

    localparam logic [3:0]    LastCnt = 4'(ACC_CYC - 1);
    localparam logic [3:0]    WeLast  = 4'(ACC_CYC - 2);
    localparam logic [AW-1:0] AddrOne = AW'(1);

    state_e        state_q, state_d;
    logic [3:0]    cnt_q, cnt_d;
    logic [AW-1:0] addr_q, addr_d;
    logic          pend_valid_q, pend_valid_d;
    logic          pend_write_q, pend_write_d;
    logic [AW-1:0] pend_addr_q, pend_addr_d;
    logic [7:0]    pend_data_q, pend_data_d;
    logic [AW-1:0] vram_addr_q, vram_addr_d;
    logic [7:0]    vram_dout_q, vram_dout_d;
    logic [7:0]    ren_data_q, ren_data_d;
    logic          ren_valid_q, ren_valid_d;
    logic [7:0]    cpu_rdata_q, cpu_rdata_d;
    logic          overrun_q, overrun_d;

    logic          slot_take;
    logic          q_new;
    logic          q_write;
    logic [AW-1:0] q_addr;

    always_ff @(posedge MCLK or negedge RESET) begin
        if (!RESET) begin
            state_q      <= StIdle;
            cnt_q        <= '0;
            addr_q       <= '0;
            pend_valid_q <= 1'b0;
            pend_write_q <= 1'b0;
            pend_addr_q  <= '0;
            pend_data_q  <= '0;
            vram_addr_q  <= '0;
            vram_dout_q  <= '0;
            ren_data_q   <= '0;
            ren_valid_q  <= 1'b0;
            cpu_rdata_q  <= '0;
            overrun_q    <= 1'b0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            addr_q       <= addr_d;
            pend_valid_q <= pend_valid_d;
            pend_write_q <= pend_write_d;
            pend_addr_q  <= pend_addr_d;
            pend_data_q  <= pend_data_d;
            vram_addr_q  <= vram_addr_d;
            vram_dout_q  <= vram_dout_d;
            ren_data_q   <= ren_data_d;
            ren_valid_q  <= ren_valid_d;
            cpu_rdata_q  <= cpu_rdata_d;
            overrun_q    <= overrun_d;
        end
    end

    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        addr_d       = addr_q;
        pend_valid_d = pend_valid_q;
        pend_write_d = pend_write_q;
        pend_addr_d  = pend_addr_q;
        pend_data_d  = pend_data_q;
        vram_addr_d  = vram_addr_q;
        vram_dout_d  = vram_dout_q;
        ren_data_d   = ren_data_q;
        ren_valid_d  = 1'b0;
        cpu_rdata_d  = cpu_rdata_q;
        overrun_d    = 1'b0;
        slot_take    = 1'b0;
        q_new        = 1'b0;
        q_write      = 1'b0;
        q_addr       = addr_q;

        // Slot service. Ticks arriving mid-access are ignored; the timing generator
        // guarantees they cannot occur.
        unique case (state_q)
            StIdle: begin
                if (slot_tick) begin
                    if (slot_type == 2'b01) begin
                        state_d     = StRen;
                        cnt_d       = '0;
                        vram_addr_d = ren_addr;
                    end else if (slot_type == 2'b00 && pend_valid_q) begin
                        state_d      = pend_write_q ? StCpuWr : StCpuRd;
                        cnt_d        = '0;
                        vram_addr_d  = pend_addr_q;
                        pend_valid_d = 1'b0;
                        slot_take    = 1'b1;
                        if (pend_write_q) begin
                            vram_dout_d = pend_data_q;
                        end
                    end
                end
            end
            default: begin
                if (cnt_q == LastCnt) begin
                    state_d = StIdle;
                    cnt_d   = '0;
                    if (state_q == StRen) begin
                        ren_data_d  = vram.vram_din;
                        ren_valid_d = 1'b1;
                    end
                    if (state_q == StCpuRd) begin
                        cpu_rdata_d = vram.vram_din;
                    end
                end else begin
                    cnt_d = cnt_q + 4'd1;
                end
            end
        endcase

        // CPU request decode; lower-priority requests in the same cycle are dropped.
        if (cpu_addr_wr) begin
            addr_d = cpu_addr;
            if (cpu_rd_ahead) begin
                q_new  = 1'b1;
                q_addr = cpu_addr;
                addr_d = cpu_addr + AddrOne;
            end
        end else if (cpu_wr_req) begin
            q_new       = 1'b1;
            q_write     = 1'b1;
            cpu_rdata_d = cpu_wdata;
            addr_d      = addr_q + AddrOne;
        end else if (cpu_rd_req) begin
            q_new  = 1'b1;
            addr_d = addr_q + AddrOne;
        end

        // An op taken by this cycle's slot has already been serviced, so replacing the
        // pending entry then is not an overrun.
        if (q_new) begin
            overrun_d    = pend_valid_q && !slot_take;
            pend_valid_d = 1'b1;
            pend_write_d = q_write;
            pend_addr_d  = q_addr;
            pend_data_d  = cpu_wdata;
        end
    end

    // Strobes decode straight from the async-reset state, so they release the moment
    // RESET asserts even in the middle of an access.
    always_comb begin
        vram.vram_ce_n = (state_q == StIdle);
        vram.vram_oe_n = !(state_q == StRen || state_q == StCpuRd);
        vram.vram_we_n = !(state_q == StCpuWr && cnt_q >= 4'd1 && cnt_q <= WeLast);
    end

    assign vram.vram_addr = vram_addr_q;
    assign vram.vram_dout = vram_dout_q;
    assign ren_data       = ren_data_q;
    assign ren_valid      = ren_valid_q;
    assign cpu_rdata      = cpu_rdata_q;
    assign cpu_overrun    = overrun_q;
    assign cpu_busy       = pend_valid_q || state_q == StCpuRd || state_q == StCpuWr;

endmodule

// File: tb/tb_vdp_vram_arbiter.sv
// Self-checking bench for vdp_vram_arbiter: a VRAM model answers reads, a monitor checks
// every access and render result against scoreboard queues filled when stimulus is driven.
module tb_vdp_vram_arbiter;

    localparam int unsigned ACC = 4;
    localparam int unsigned AW  = 14;

    typedef struct {
        bit         wr;
        logic [13:0] addr;
        logic [7:0]  data;
    } acc_t;

    logic        MCLK = 1'b0;
    logic        RESET;
    logic        slot_tick;
    logic [1:0]  slot_type;
    logic [13:0] ren_addr;
    logic [7:0]  ren_data;
    logic        ren_valid;
    logic        cpu_addr_wr;
    logic [13:0] cpu_addr;
    logic        cpu_rd_ahead;
    logic        cpu_rd_req;
    logic        cpu_wr_req;
    logic [7:0]  cpu_wdata;
    logic [7:0]  cpu_rdata;
    logic        cpu_busy;
    logic        cpu_overrun;

    vdp_vram_arbiter_if #(.AW(AW)) vif ();

    vdp_vram_arbiter #(.ACC_CYC(ACC), .AW(AW)) dut (
        .MCLK        (MCLK),
        .RESET       (RESET),
        .slot_tick   (slot_tick),
        .slot_type   (slot_type),
        .ren_addr    (ren_addr),
        .ren_data    (ren_data),
        .ren_valid   (ren_valid),
        .cpu_addr_wr (cpu_addr_wr),
        .cpu_addr    (cpu_addr),
        .cpu_rd_ahead(cpu_rd_ahead),
        .cpu_rd_req  (cpu_rd_req),
        .cpu_wr_req  (cpu_wr_req),
        .cpu_wdata   (cpu_wdata),
        .cpu_rdata   (cpu_rdata),
        .cpu_busy    (cpu_busy),
        .cpu_overrun (cpu_overrun),
        .vram        (vif)
    );

    always #5 MCLK = ~MCLK;

    logic [7:0] mem [16384];
    bit         mem_init = 1'b0;
    assign vif.vram_din = mem[vif.vram_addr];

    int n_checks = 0;
    int n_errors = 0;

    acc_t       exp_acc [$];
    logic [7:0] exp_ren [$];

    // Bench model of the CPU side.
    logic        m_pv;
    logic        m_pwr;
    logic [13:0] m_paddr;
    logic [7:0]  m_pdata;
    logic [13:0] m_addr;
    logic [7:0]  m_rdata;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic cyc();
        @(posedge MCLK);
        #1;
    endtask

    // VRAM monitor: owns the memory contents and pops one expectation per access.
    bit          in_acc = 1'b0;
    int          n_ce, n_oe, n_we;
    logic [13:0] a0;
    logic [7:0]  d0;
    bit          unstable;

    always @(negedge MCLK) begin
        if (!mem_init) begin
            for (int i = 0; i < 16384; i++) mem[i] = 8'((i * 7 + 3) ^ (i >> 6));
            mem[14'h1234] = 8'h5A;
            mem[14'h0800] = 8'h3C;
            mem_init = 1'b1;
        end
        if (!RESET) begin
            in_acc = 1'b0;
        end else if (!vif.vram_ce_n) begin
            if (!in_acc) begin
                in_acc   = 1'b1;
                n_ce     = 0;
                n_oe     = 0;
                n_we     = 0;
                a0       = vif.vram_addr;
                d0       = vif.vram_dout;
                unstable = 1'b0;
            end
            n_ce++;
            if (!vif.vram_oe_n) n_oe++;
            if (!vif.vram_we_n) n_we++;
            if (vif.vram_addr != a0 || vif.vram_dout != d0) unstable = 1'b1;
        end else begin
            check("idle_strobes", {30'd0, vif.vram_oe_n, vif.vram_we_n}, 32'd3);
            if (in_acc) begin
                acc_t e;
                in_acc = 1'b0;
                if (exp_acc.size() == 0) begin
                    check("acc_unexpected", {18'd0, a0}, 32'hFFFF_FFFF);
                end else begin
                    e = exp_acc.pop_front();
                    check("acc_addr", {18'd0, a0}, {18'd0, e.addr});
                    check("acc_ce_len", n_ce, ACC);
                    check("acc_oe_len", n_oe, e.wr ? 0 : ACC);
                    check("acc_we_len", n_we, e.wr ? ACC - 2 : 0);
                    check("acc_stable", {31'd0, unstable}, 0);
                    if (e.wr) begin
                        check("acc_wdata", {24'd0, d0}, {24'd0, e.data});
                        mem[a0] = d0;
                    end
                end
            end
        end
        if (RESET && ren_valid) begin
            if (exp_ren.size() == 0) check("ren_unexpected", {24'd0, ren_data}, 32'hFFFF_FFFF);
            else check("ren_data", {24'd0, ren_data}, {24'd0, exp_ren.pop_front()});
        end
    end

    // One cycle of stimulus; when a slot ticks, waits out the access and checks latency.
    task automatic drive(input bit st, input logic [1:0] ty, input logic [13:0] ra,
                         input bit aw, input bit ah, input logic [13:0] a,
                         input bit wr, input logic [7:0] d, input bit rd);
        bit          svc = 1'b0;
        bit          svc_rd = 1'b0;
        logic [13:0] svc_addr = '0;
        bit          q = 1'b0;
        bit          ovr = 1'b0;
        acc_t        e;
        if (rd && !aw && !wr) check("rd_return", {24'd0, cpu_rdata}, {24'd0, m_rdata});
        if (st) begin
            if (ty == 2'b01) begin
                e.wr = 1'b0; e.addr = ra; e.data = mem[ra];
                exp_acc.push_back(e);
                exp_ren.push_back(mem[ra]);
            end else if (ty == 2'b00 && m_pv) begin
                e.wr = m_pwr; e.addr = m_paddr; e.data = m_pdata;
                exp_acc.push_back(e);
                svc = 1'b1; svc_rd = !m_pwr; svc_addr = m_paddr;
                m_pv = 1'b0;
            end
        end
        if (aw) begin
            m_addr = a;
            if (ah) begin
                q = 1'b1; m_pwr = 1'b0; m_paddr = a; m_addr = a + 14'd1;
            end
        end else if (wr) begin
            q = 1'b1; m_pwr = 1'b1; m_paddr = m_addr; m_rdata = d; m_addr = m_addr + 14'd1;
        end else if (rd) begin
            q = 1'b1; m_pwr = 1'b0; m_paddr = m_addr; m_addr = m_addr + 14'd1;
        end
        if (q) begin
            ovr = m_pv; m_pv = 1'b1; m_pdata = d;
        end
        slot_tick = st; slot_type = ty; ren_addr = ra;
        cpu_addr_wr = aw; cpu_rd_ahead = ah; cpu_addr = a;
        cpu_wr_req = wr; cpu_wdata = d; cpu_rd_req = rd;
        cyc();
        slot_tick = 1'b0; cpu_addr_wr = 1'b0; cpu_rd_ahead = 1'b0;
        cpu_wr_req = 1'b0; cpu_rd_req = 1'b0;
        check("overrun", {31'd0, cpu_overrun}, {31'd0, ovr});
        check("busy", {31'd0, cpu_busy}, {31'd0, m_pv | svc});
        if (wr && !aw) check("wr_rdata", {24'd0, cpu_rdata}, {24'd0, d});
        if (st) begin
            for (int i = 1; i < ACC; i++) cyc();
            check("rdata_pre", {24'd0, cpu_rdata}, {24'd0, m_rdata});
            check("ren_valid_pre", {31'd0, ren_valid}, 0);
            cyc();
            if (svc_rd) m_rdata = mem[svc_addr];
            check("rdata_lat", {24'd0, cpu_rdata}, {24'd0, m_rdata});
            check("ren_valid_lat", {31'd0, ren_valid}, {31'd0, ty == 2'b01});
            check("busy_end", {31'd0, cpu_busy}, {31'd0, m_pv});
            cyc();
            check("acc_done", exp_acc.size(), 0);
            check("ren_done", exp_ren.size(), 0);
        end
    endtask

    task automatic t_addr(input logic [13:0] a, input bit ah);
        drive(1'b0, 2'b00, 14'd0, 1'b1, ah, a, 1'b0, 8'd0, 1'b0);
    endtask
    task automatic t_wr(input logic [7:0] d);
        drive(1'b0, 2'b00, 14'd0, 1'b0, 1'b0, 14'd0, 1'b1, d, 1'b0);
    endtask
    task automatic t_rd();
        drive(1'b0, 2'b00, 14'd0, 1'b0, 1'b0, 14'd0, 1'b0, 8'd0, 1'b1);
    endtask
    task automatic t_slot(input logic [1:0] ty, input logic [13:0] ra);
        drive(1'b1, ty, ra, 1'b0, 1'b0, 14'd0, 1'b0, 8'd0, 1'b0);
    endtask

    task automatic check_reset_vals(input string tag);
        check({tag, "_ren_data"}, {24'd0, ren_data}, 0);
        check({tag, "_ren_valid"}, {31'd0, ren_valid}, 0);
        check({tag, "_cpu_rdata"}, {24'd0, cpu_rdata}, 0);
        check({tag, "_busy"}, {31'd0, cpu_busy}, 0);
        check({tag, "_overrun"}, {31'd0, cpu_overrun}, 0);
        check({tag, "_vram_addr"}, {18'd0, vif.vram_addr}, 0);
        check({tag, "_vram_dout"}, {24'd0, vif.vram_dout}, 0);
        check({tag, "_strobes"}, {29'd0, vif.vram_ce_n, vif.vram_oe_n, vif.vram_we_n}, 7);
    endtask

    task automatic model_reset();
        m_pv = 1'b0; m_pwr = 1'b0; m_paddr = '0; m_pdata = '0; m_addr = '0; m_rdata = '0;
        exp_acc.delete();
        exp_ren.delete();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        RESET = 1'b0;
        slot_tick = 1'b0; slot_type = 2'b00; ren_addr = '0;
        cpu_addr_wr = 1'b0; cpu_addr = '0; cpu_rd_ahead = 1'b0;
        cpu_rd_req = 1'b0; cpu_wr_req = 1'b0; cpu_wdata = '0;
        model_reset();
        repeat (3) cyc();
        check_reset_vals("rst");
        RESET = 1'b1;
        cyc();

        // Read-ahead: data lands ACC+1 cycles after the tick, then a CPU read returns it.
        t_addr(14'h1234, 1'b1);
        t_slot(2'b00, 14'd0);
        check("rdahead_5a", {24'd0, cpu_rdata}, 32'h5A);
        t_rd();
        t_slot(2'b00, 14'd0);

        // Write at the top of the address space, then the address wraps to 0000.
        t_addr(14'h3FFF, 1'b0);
        t_wr(8'hA7);
        t_slot(2'b00, 14'd0);
        t_rd();
        t_slot(2'b00, 14'd0);

        // Render slot does not service the pending write; busy holds until a CPU slot.
        t_addr(14'h0100, 1'b0);
        t_wr(8'h99);
        t_slot(2'b01, 14'h0800);
        check("ren_3c", {24'd0, ren_data}, 32'h3C);
        t_slot(2'b00, 14'd0);

        // Overrun: second write replaces the first, address advances by two.
        t_addr(14'h0200, 1'b0);
        t_wr(8'h11);
        t_wr(8'h22);
        t_slot(2'b00, 14'd0);
        t_rd();
        t_slot(2'b00, 14'd0);

        // Address load beats a same-cycle write; empty CPU and refresh slots do nothing.
        drive(1'b0, 2'b00, 14'd0, 1'b1, 1'b0, 14'h0300, 1'b1, 8'hEE, 1'b0);
        t_slot(2'b00, 14'd0);
        t_wr(8'h5C);
        t_slot(2'b10, 14'd0);
        t_slot(2'b11, 14'd0);
        t_slot(2'b00, 14'd0);

        // Request in the tick cycle waits; one taken by that tick is not an overrun.
        drive(1'b1, 2'b00, 14'd0, 1'b0, 1'b0, 14'd0, 1'b1, 8'h6B, 1'b0);
        drive(1'b1, 2'b00, 14'd0, 1'b0, 1'b0, 14'd0, 1'b1, 8'h6C, 1'b0);
        t_slot(2'b00, 14'd0);

        // Asynchronous reset in the middle of a write access.
        t_addr(14'h0400, 1'b0);
        t_wr(8'h77);
        slot_tick = 1'b1; slot_type = 2'b00;
        cyc();
        slot_tick = 1'b0;
        cyc();
        check("we_mid", {31'd0, vif.vram_we_n}, 0);
        #2;
        RESET = 1'b0;
        #1;
        check_reset_vals("mid");
        model_reset();
        repeat (2) cyc();
        RESET = 1'b1;
        cyc();
        t_rd();
        t_slot(2'b00, 14'd0);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
